fetch_seq: RTL and testbench
============================

Name: fetch_seq

Overview:
Fetch sequencer that drives the program counter register's next-address input and owns the instruction-fetch handshake. It issues one instruction-memory request at a time at the current PC. It hands fetched words to decode with a valid/ready handshake. It applies redirects (branch/jump) with priority and steers misaligned targets to a trap vector.

Parameters:
RESET_VEC, 32'h0000_0000, PC loaded in the BOOT cycle after reset
TRAP_VEC, 32'h0000_0100, PC loaded on a misaligned redirect target
INSN_BYTES, 4, PC increment per retired fetch

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
pc  input  32  current PC, from the PC register
pc_next  output  32  next PC, to the PC register; that register loads it every cycle
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  32  fetch address, equal to pc
imem_rsp_valid  input  1  response word valid, one-cycle pulse, never before request accept
imem_rsp_data  input  32  instruction word
inst_valid  output  1  instruction available to decode
inst_ready  input  1  decode accepts instruction
inst  output  32  held instruction word
inst_pc  output  32  address of the held instruction
redirect_valid  input  1  branch/jump taken, one-cycle pulse
redirect_target  input  32  redirect address
halt  input  1  level; stop issuing new fetches
trap  output  1  one-cycle pulse on misaligned redirect
halted  output  1  high in HALTED state

Behaviour:
- Reset (async, rst=1): state=BOOT, drop=0, inst=0, inst_pc=0, trap=0. All valid outputs are 0 and pc_next=RESET_VEC while rst is asserted.
- States: BOOT, REQ, RSP, HOLD, HALTED.
- BOOT: one cycle. pc_next=RESET_VEC. Next state is REQ.
- REQ: imem_req_valid=1, imem_req_addr=pc. On imem_req_ready the state goes to RSP. If halt=1 on entry, valid stays 0 and the state goes to HALTED. Once valid is asserted it holds until accepted; halt does not withdraw it.
- RSP: waits for imem_rsp_valid.
  - If drop=0: latch inst=imem_rsp_data and inst_pc=pc, then go to HOLD.
  - If drop=1: discard the word, clear drop, go to REQ.
- HOLD: inst_valid=1.
  - On inst_ready: pc_next=pc+INSN_BYTES (32-bit wrap, 32'hFFFF_FFFC becomes 0). Next state is REQ, or HALTED if halt=1.
- HALTED: halted=1 and no requests. When halt deasserts, go to REQ.
- Default: pc_next=pc, so the PC holds.
- Redirect (any state except BOOT) has priority over increment:
  - Aligned target (target[1:0]=0): pc_next=redirect_target.
  - Misaligned target: pc_next=TRAP_VEC and trap=1 for that cycle.
  - Effect by state:
    - In HOLD: inst_valid drops the next cycle, the word is discarded (even if inst_ready was 1 the same cycle), and the state goes to REQ.
    - In RSP: set drop=1 unless imem_rsp_valid is high the same cycle. In that case the word is discarded directly and the state goes to REQ.
    - In REQ: if the request is accepted the same cycle, go to RSP with drop=1. Otherwise stay in REQ with the new address next cycle.
    - In HALTED: the PC updates and the state remains HALTED.
- Redirect in BOOT is ignored.
- Throughput: 1 instruction per 3 cycles minimum (REQ, RSP, HOLD) with zero-wait memory. At most one outstanding request.
- inst and inst_pc are stable while inst_valid=1 and inst_ready=0.
- Reset mid-operation: an outstanding response is lost. The memory must also be reset by rst.

Test Plan:
- Reset then free-run, memory always ready with 1-cycle response, inst_ready=1 -> pc_next=0 in BOOT; inst_pc sequence 0,4,8,C; inst_valid pulses every 3 cycles.
- Backpressure: inst_ready=0 for 5 cycles in HOLD at pc=8 -> inst_valid stays 1; inst and inst_pc stable; pc_next=8 throughout; no new request.
- Redirect in RSP to 0x40, response arrives 2 cycles later -> response dropped; next request address 0x40; first delivered inst_pc=0x40.
- Misaligned redirect to 0x42 in HOLD -> trap pulses once; pc_next=0x100; held instruction not delivered; next fetch at 0x100.
- halt asserted in HOLD with inst_ready=1 at pc=4 -> pc advances to 8, HALTED, halted=1, imem_req_valid=0. Deassert halt -> request at 8.
- rst asserted in RSP, then released -> outputs cleared immediately; BOOT drives RESET_VEC; fetch restarts at RESET_VEC.

Source files
------------

// File: rtl/fetch_seq_if.sv
// Fetch sequencer bus: PC register link, instruction-memory request/response,
// decode handoff, redirect and halt control.
interface fetch_seq_if;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        halt;
  logic        trap;
  logic        halted;

  modport master (
    input  pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
           redirect_valid, redirect_target, halt,
    output pc_next, imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
           trap, halted
  );

  modport slave (
    output pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
           redirect_valid, redirect_target, halt,
    input  pc_next, imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
           trap, halted
  );
endinterface

// File: rtl/fetch_seq.sv
// Fetch sequencer: one outstanding instruction fetch at the current PC, hands words
// to decode, and applies branch/jump redirects with priority over sequential advance.
module fetch_seq #(
  parameter logic [31:0] RESET_VEC  = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC   = 32'h0000_0100,
  parameter int unsigned INSN_BYTES = 4
) (
  input logic         i_clk,
  input logic         i_rst,
  fetch_seq_if.master io_bus
);

  typedef enum logic [2:0] {StBoot, StReq, StRsp, StHold, StHalted} state_e;

  state_e      r_state, w_state_nxt;
  logic        r_drop, w_drop_nxt;
  logic        r_req_issued, w_req_issued_nxt;
  logic [31:0] r_inst, w_inst_nxt;
  logic [31:0] r_inst_pc, w_inst_pc_nxt;

  logic        w_redir;
  logic        w_misaligned;
  logic [31:0] w_redir_pc;
  logic [31:0] w_pc_next;
  logic        w_req_valid;
  logic        w_inst_valid;
  logic        w_trap;
  logic        w_halted;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= StBoot;
      r_drop       <= 1'b0;
      r_req_issued <= 1'b0;
      r_inst       <= 32'h0;
      r_inst_pc    <= 32'h0;
    end else begin
      r_state      <= w_state_nxt;
      r_drop       <= w_drop_nxt;
      r_req_issued <= w_req_issued_nxt;
      r_inst       <= w_inst_nxt;
      r_inst_pc    <= w_inst_pc_nxt;
    end
  end

  assign w_redir      = io_bus.redirect_valid && (r_state != StBoot);
  assign w_misaligned = io_bus.redirect_target[1:0] != 2'b00;
  assign w_redir_pc   = w_misaligned ? TRAP_VEC : io_bus.redirect_target;

  always_comb begin
    w_state_nxt      = r_state;
    w_drop_nxt       = r_drop;
    w_req_issued_nxt = 1'b0;
    w_inst_nxt       = r_inst;
    w_inst_pc_nxt    = r_inst_pc;
    w_pc_next        = io_bus.pc;
    w_req_valid      = 1'b0;
    w_inst_valid     = 1'b0;
    w_trap           = 1'b0;
    w_halted         = 1'b0;

    unique case (r_state)
      StBoot: begin
        w_pc_next   = RESET_VEC;
        w_state_nxt = StReq;
      end
      StReq: begin
        // halt only suppresses a request that has not been presented yet
        w_req_valid = r_req_issued || !io_bus.halt;
        if (!w_req_valid) begin
          w_state_nxt = StHalted;
        end else if (io_bus.imem_req_ready) begin
          w_state_nxt = StRsp;
          w_drop_nxt  = w_redir;
        end else begin
          w_req_issued_nxt = 1'b1;
        end
      end
      StRsp: begin
        if (io_bus.imem_rsp_valid) begin
          if (r_drop || w_redir) begin
            w_state_nxt = StReq;
            w_drop_nxt  = 1'b0;
          end else begin
            w_inst_nxt    = io_bus.imem_rsp_data;
            w_inst_pc_nxt = io_bus.pc;
            w_state_nxt   = StHold;
          end
        end else if (w_redir) begin
          w_drop_nxt = 1'b1;
        end
      end
      StHold: begin
        w_inst_valid = 1'b1;
        if (w_redir) begin
          w_state_nxt = StReq;
        end else if (io_bus.inst_ready) begin
          w_pc_next   = io_bus.pc + 32'(INSN_BYTES);
          w_state_nxt = io_bus.halt ? StHalted : StReq;
        end
      end
      StHalted: begin
        w_halted = 1'b1;
        if (!io_bus.halt && !w_redir) begin
          w_state_nxt = StReq;
        end
      end
      default: w_state_nxt = StBoot;
    endcase

    if (w_redir) begin
      w_pc_next = w_redir_pc;
      w_trap    = w_misaligned;
    end
  end

  assign io_bus.pc_next        = w_pc_next;
  assign io_bus.imem_req_valid = w_req_valid;
  assign io_bus.imem_req_addr  = io_bus.pc;
  assign io_bus.inst_valid     = w_inst_valid;
  assign io_bus.inst           = r_inst;
  assign io_bus.inst_pc        = r_inst_pc;
  assign io_bus.trap           = w_trap;
  assign io_bus.halted         = w_halted;

endmodule

// File: tb/tb_fetch_seq.sv
// Bench for fetch_seq: PC register and latency-configurable memory around the DUT,
// directed scenarios followed by random traffic against a program-flow scoreboard.
module tb_fetch_seq;

  localparam logic [31:0] RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC  = 32'h0000_0100;

  logic clk;
  logic rst;
  fetch_seq_if bus ();

  fetch_seq #(
    .RESET_VEC (RESET_VEC),
    .TRAP_VEC  (TRAP_VEC),
    .INSN_BYTES(4)
  ) u_dut (
    .i_clk (clk),
    .i_rst (rst),
    .io_bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PC register loads pc_next every cycle
  always @(posedge clk) bus.pc <= bus.pc_next;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h9E37_79B9;
  endfunction

  // Memory: response m_lat cycles after accept (1 = the cycle right after accept)
  int          m_lat;
  logic        m_busy;
  int          m_cnt;
  logic [31:0] m_addr;
  int          m_overlap;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy             <= 1'b0;
      m_cnt              <= 0;
      m_addr             <= 32'h0;
      bus.imem_rsp_valid <= 1'b0;
    end else begin
      bus.imem_rsp_valid <= 1'b0;
      if (m_busy) begin
        if (m_cnt <= 1) begin
          bus.imem_rsp_valid <= 1'b1;
          bus.imem_rsp_data  <= mem_word(m_addr);
          m_busy             <= 1'b0;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        if (m_busy || bus.imem_rsp_valid) m_overlap <= m_overlap + 1;
        if (m_lat <= 1) begin
          bus.imem_rsp_valid <= 1'b1;
          bus.imem_rsp_data  <= mem_word(bus.imem_req_addr);
        end else begin
          m_busy <= 1'b1;
          m_cnt  <= m_lat - 1;
          m_addr <= bus.imem_req_addr;
        end
      end
    end
  end

  int          n_cmp;
  int          n_err;
  int          since_rst;
  logic [31:0] exp_pc;
  logic        prev_hold;
  logic [31:0] prev_inst;
  logic [31:0] prev_inst_pc;
  int          deliv_cyc[$];
  logic [31:0] deliv_pc[$];
  int          n_traps;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Scoreboard tracks the architectural fetch stream: where the next delivered word must be from
  task automatic cycle();
    logic [31:0] tgt;
    #1;
    if (rst) begin
      check_eq("rst_pc_next", bus.pc_next, RESET_VEC);
      check_eq("rst_req_valid", bus.imem_req_valid, 1'b0);
      check_eq("rst_inst_valid", bus.inst_valid, 1'b0);
      check_eq("rst_inst", bus.inst, 32'h0);
      check_eq("rst_inst_pc", bus.inst_pc, 32'h0);
      check_eq("rst_trap", bus.trap, 1'b0);
      since_rst = 0;
      exp_pc    = RESET_VEC;
      prev_hold = 1'b0;
    end else begin
      if (since_rst == 0) begin
        check_eq("boot_pc_next", bus.pc_next, RESET_VEC);
        check_eq("boot_req_valid", bus.imem_req_valid, 1'b0);
      end else begin
        if (bus.imem_req_valid) check_eq("req_addr", bus.imem_req_addr, bus.pc);
        if (bus.halted) check_eq("halted_no_req", bus.imem_req_valid, 1'b0);
        if (prev_hold) begin
          check_eq("hold_valid", bus.inst_valid, 1'b1);
          check_eq("hold_inst", bus.inst, prev_inst);
          check_eq("hold_inst_pc", bus.inst_pc, prev_inst_pc);
        end
        if (bus.redirect_valid) begin
          tgt = bus.redirect_target;
          exp_pc = (tgt[1:0] == 2'b00) ? tgt : TRAP_VEC;
          check_eq("redir_pc_next", bus.pc_next, exp_pc);
          check_eq("redir_trap", bus.trap, tgt[1:0] != 2'b00);
          if (bus.trap) n_traps++;
        end else if (bus.inst_valid && bus.inst_ready) begin
          check_eq("deliv_pc", bus.inst_pc, exp_pc);
          check_eq("deliv_word", bus.inst, mem_word(exp_pc));
          exp_pc = exp_pc + 32'd4;
          check_eq("deliv_pc_next", bus.pc_next, exp_pc);
          deliv_cyc.push_back(since_rst);
          deliv_pc.push_back(bus.inst_pc);
        end else begin
          check_eq("pc_hold", bus.pc_next, bus.pc);
          check_eq("no_trap", bus.trap, 1'b0);
        end
      end
      prev_hold    = bus.inst_valid && !bus.inst_ready && !bus.redirect_valid;
      prev_inst    = bus.inst;
      prev_inst_pc = bus.inst_pc;
      since_rst++;
    end
    @(negedge clk);
  endtask

  task automatic wait_req(input string tag, input int max);
    int n = 0;
    while (!bus.imem_req_valid && n < max) begin
      cycle();
      n++;
    end
    check_eq(tag, bus.imem_req_valid, 1'b1);
  endtask

  task automatic wait_inst(input string tag, input int max);
    int n = 0;
    while (!bus.inst_valid && n < max) begin
      cycle();
      n++;
    end
    check_eq(tag, bus.inst_valid, 1'b1);
  endtask

  initial begin
    int n;
    int halt_left;
    int base_deliv;
    n_cmp = 0;
    n_err = 0;
    n_traps = 0;
    m_overlap = 0;
    m_lat = 1;
    since_rst = 0;
    exp_pc = RESET_VEC;
    prev_hold = 1'b0;
    rst = 1'b1;
    bus.imem_req_ready  = 1'b1;
    bus.inst_ready      = 1'b1;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = 32'h0;
    bus.halt            = 1'b0;
    @(negedge clk);
    repeat (3) cycle();
    rst = 1'b0;

    // Free run with backpressure at pc=8
    for (int i = 0; i < 9; i++) cycle();
    check_eq("bp_valid", bus.inst_valid, 1'b1);
    check_eq("bp_inst_pc", bus.inst_pc, 32'h8);
    bus.inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("bp_pc_next", bus.pc_next, 32'h8);
      check_eq("bp_no_req", bus.imem_req_valid, 1'b0);
      cycle();
    end
    bus.inst_ready = 1'b1;
    n = 0;
    while (deliv_cyc.size() < 4 && n < 10) begin
      cycle();
      n++;
    end
    check_eq("fr_count", deliv_cyc.size(), 4);
    if (deliv_cyc.size() >= 4) begin
      check_eq("fr_first_cyc", deliv_cyc[0], 3);
      check_eq("fr_second_cyc", deliv_cyc[1], 6);
      check_eq("fr_bp_release_cyc", deliv_cyc[2], 14);
      check_eq("fr_spacing", deliv_cyc[3] - deliv_cyc[2], 3);
      check_eq("fr_pc3", deliv_pc[3], 32'hC);
    end

    // Redirect in RSP to 0x40, response two cycles later
    m_lat = 3;
    wait_req("rsp_redir_req", 10);
    cycle();
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h40;
    #1 check_eq("rsp_redir_pc_next", bus.pc_next, 32'h40);
    cycle();
    bus.redirect_valid = 1'b0;
    wait_req("rsp_redir_next_req", 10);
    check_eq("rsp_redir_addr", bus.imem_req_addr, 32'h40);
    wait_inst("rsp_redir_inst", 10);
    check_eq("rsp_redir_inst_pc", bus.inst_pc, 32'h40);

    // Misaligned redirect in HOLD, word discarded despite inst_ready
    m_lat = 1;
    bus.inst_ready = 1'b0;
    wait_inst("mis_hold", 10);
    n_traps = 0;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h42;
    bus.inst_ready      = 1'b1;
    #1;
    check_eq("mis_trap", bus.trap, 1'b1);
    check_eq("mis_pc_next", bus.pc_next, TRAP_VEC);
    cycle();
    bus.redirect_valid = 1'b0;
    bus.inst_ready     = 1'b0;
    #1;
    check_eq("mis_trap_gone", bus.trap, 1'b0);
    check_eq("mis_inst_dropped", bus.inst_valid, 1'b0);
    wait_req("mis_req", 10);
    check_eq("mis_req_addr", bus.imem_req_addr, TRAP_VEC);
    check_eq("mis_trap_count", n_traps, 1);
    bus.inst_ready = 1'b1;

    // Reset while a response is outstanding
    m_lat = 2;
    cycle();
    wait_req("rstmid_req", 10);
    cycle();
    rst = 1'b1;
    #1;
    check_eq("rstmid_inst_valid", bus.inst_valid, 1'b0);
    check_eq("rstmid_req_valid", bus.imem_req_valid, 1'b0);
    check_eq("rstmid_pc_next", bus.pc_next, RESET_VEC);
    check_eq("rstmid_inst", bus.inst, 32'h0);
    check_eq("rstmid_halted", bus.halted, 1'b0);
    cycle();
    cycle();
    rst = 1'b0;
    m_lat = 1;
    wait_req("rstmid_restart", 10);
    check_eq("rstmid_restart_addr", bus.imem_req_addr, RESET_VEC);

    // Halt in HOLD at pc=4 with inst_ready
    n = 0;
    while (!(bus.inst_valid && bus.inst_pc == 32'h4) && n < 20) begin
      cycle();
      n++;
    end
    check_eq("halt_reach_pc4", bus.inst_pc, 32'h4);
    bus.halt = 1'b1;
    #1 check_eq("halt_pc_next", bus.pc_next, 32'h8);
    cycle();
    #1;
    check_eq("halt_halted", bus.halted, 1'b1);
    check_eq("halt_no_req", bus.imem_req_valid, 1'b0);
    check_eq("halt_pc", bus.pc, 32'h8);
    cycle();
    cycle();
    check_eq("halt_still", bus.halted, 1'b1);
    bus.halt = 1'b0;
    cycle();
    #1;
    check_eq("unhalt_req", bus.imem_req_valid, 1'b1);
    check_eq("unhalt_addr", bus.imem_req_addr, 32'h8);

    // Random traffic
    base_deliv = deliv_cyc.size();
    halt_left = 0;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] t;
      bus.imem_req_ready = ($urandom_range(0, 3) != 0);
      m_lat = $urandom_range(1, 3);
      bus.inst_ready = ($urandom_range(0, 9) < 7);
      if (halt_left > 0) begin
        bus.halt = 1'b1;
        halt_left--;
      end else begin
        bus.halt = 1'b0;
        if ($urandom_range(0, 99) == 0) halt_left = $urandom_range(1, 8);
      end
      bus.redirect_valid = 1'b0;
      if ($urandom_range(0, 29) == 0) begin
        t = $urandom & 32'h0000_0FFC;
        if ($urandom_range(0, 3) == 0) t[1:0] = 2'($urandom_range(1, 3));
        if ($urandom_range(0, 7) == 0) t = 32'hFFFF_FFF8;
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = t;
      end
      cycle();
    end
    bus.redirect_valid = 1'b0;
    bus.halt = 1'b0;
    check_eq("rand_progress", (deliv_cyc.size() - base_deliv) > 100, 1'b1);
    check_eq("one_outstanding", m_overlap, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
